// File: rtl/sap3_div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the FSM state encoding, the default operand width and the step-counter width.
package sap3_div_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int CNT_W      = $clog2(DW_DEFAULT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cntWidth(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {R,Q} left, trial-subtract the divisor,
// and keep the difference only when it does not borrow.
module div_step #(
  parameter int DW = 8
) (
  input  logic [DW:0]   i_rem,
  input  logic [DW-1:0] i_q,
  input  logic [DW-1:0] i_divisor,
  output logic [DW:0]   o_rem,
  output logic [DW-1:0] o_q
);

  logic [DW:0]   w_shifted;
  logic [DW+1:0] w_trial;
  logic          w_borrow;
  logic          w_unused_msb;

  // R stays below the divisor between steps, so its MSB is always zero
  // and the shifted value still fits in DW+1 bits.
  assign w_unused_msb = i_rem[DW];
  assign w_shifted    = {i_rem[DW-1:0], i_q[DW-1]};
  assign w_trial      = {1'b0, w_shifted} - {2'b00, i_divisor};
  assign w_borrow     = w_trial[DW+1];

  assign o_rem = w_borrow ? w_shifted : w_trial[DW:0];
  assign o_q   = {i_q[DW-2:0], ~w_borrow};

endmodule

// File: rtl/seq_divider.sv
// Sequential 2*DW / DW unsigned restoring divider, one quotient bit per clock.
// Divide-by-zero and quotient overflow are detected at start and skip iteration.
module seq_divider
  import sap3_div_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_by_zero,
  output logic            overflow
);

  localparam int CW = cntWidth(DW);
  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

  state_t        r_state;
  logic [DW:0]   r_rem;
  logic [DW-1:0] r_q;
  logic [DW-1:0] r_divisor;
  logic [CW-1:0] r_cnt;

  logic [DW:0]   w_rem_next;
  logic [DW-1:0] w_q_next;
  logic          w_unused_msb;

  assign w_unused_msb = w_rem_next[DW];

  div_step #(.DW(DW)) u_step (
    .i_rem     (r_rem),
    .i_q       (r_q),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_q       (w_q_next)
  );

  // Results stay put from one done pulse until the next accepted start's done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_q         <= '0;
      r_divisor   <= '0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            r_divisor   <= divisor;
            r_cnt       <= '0;
            if (divisor == '0) begin
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= '0;
              done        <= 1'b1;
              r_state     <= DONE;
            end else if (dividend[2*DW-1:DW] >= divisor) begin
              overflow  <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
              done      <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_rem   <= {1'b0, dividend[2*DW-1:DW]};
              r_q     <= dividend[DW-1:0];
              busy    <= 1'b1;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= w_q_next;
            remainder <= w_rem_next[DW-1:0];
            r_state   <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus randomized
// back-to-back divides compared against plain arithmetic.
module tb_seq_divider;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [2*DW-1:0] dividend;
  logic [DW-1:0]   divisor;
  logic            busy;
  logic            done;
  logic [DW-1:0]   quotient;
  logic [DW-1:0]   remainder;
  logic            div_by_zero;
  logic            overflow;

  int compared   = 0;
  int mismatched = 0;

  seq_divider #(.DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge one cycle after done.
  // pokeAt > 0 pulses start with fresh operands at that cycle; scramble
  // changes operands every cycle after the start was sampled.
  task automatic applyStimulus(input logic [15:0] dd, input logic [7:0] dv,
                               input int pokeAt, input bit scramble);
    int unsigned udd, udv;
    logic [7:0]  eq, er;
    bit          edz, eov, err, seen;
    int          expLat;
    udd = 32'(dd);
    udv = 32'(dv);
    edz = (udv == 0);
    eov = !edz && ((udd >> 8) >= udv);
    err = edz || eov;
    if (err) begin
      eq = 8'hFF;
      er = 8'h00;
    end else begin
      eq = 8'(udd / udv);
      er = 8'(udd % udv);
    end
    expLat = err ? 1 : DW + 1;

    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    seen     = 1'b0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n < expLat) begin
        checkOutput("busyInCalc", 32'(busy), 32'd1);
        checkOutput("doneEarly", 32'(done), 32'd0);
      end else if (n == expLat) begin
        seen = 1'b1;
        checkOutput("doneAtLatency", 32'(done), 32'd1);
        checkOutput("busyAtDone", 32'(busy), 32'd0);
        checkOutput("quotient", 32'(quotient), 32'(eq));
        checkOutput("remainder", 32'(remainder), 32'(er));
        checkOutput("divByZero", 32'(div_by_zero), 32'(edz));
        checkOutput("overflow", 32'(overflow), 32'(eov));
        if (!err) begin
          checkOutput("identity", 32'(quotient) * udv + 32'(remainder), udd);
          checkOutput("remLtDivisor", 32'(32'(remainder) < udv), 32'd1);
        end
      end
      if (pokeAt > 0 && n == pokeAt) begin
        start    = 1'b1;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
      end else if (pokeAt > 0 && n == pokeAt + 1) begin
        start = 1'b0;
      end else if (scramble) begin
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
      end
    end
    if (!seen) checkOutput("doneTimeout", 32'd0, 32'd1);

    @(negedge clk);
    checkOutput("donePulseWidth", 32'(done), 32'd0);
    checkOutput("busyAfterDone", 32'(busy), 32'd0);
    checkOutput("quotientHold", 32'(quotient), 32'(eq));
    checkOutput("remainderHold", 32'(remainder), 32'(er));
    start = 1'b0;
  endtask

  task automatic checkIdle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checkOutput({tag, "Done"}, 32'(done), 32'd0);
      checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "Done"}, 32'(done), 32'd0);
    checkOutput({tag, "Quotient"}, 32'(quotient), 32'd0);
    checkOutput({tag, "Remainder"}, 32'(remainder), 32'd0);
    checkOutput({tag, "DivByZero"}, 32'(div_by_zero), 32'd0);
    checkOutput({tag, "Overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    logic [7:0]  rdv, rhi, rlo;
    int unsigned sel;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed divides");
    applyStimulus(16'd100, 8'd7, 0, 1'b0);
    applyStimulus(16'hFE01, 8'hFF, 0, 1'b0);
    applyStimulus(16'h00FF, 8'hFF, 0, 1'b0);
    applyStimulus(16'd1000, 8'd0, 0, 1'b0);
    applyStimulus(16'h0800, 8'h05, 0, 1'b0);
    applyStimulus(16'h07FF, 8'h08, 0, 1'b0);

    $display("[TB] start during CALC and during DONE");
    applyStimulus(16'd200, 8'd9, 3, 1'b0);
    applyStimulus(16'd1234, 8'd56, DW + 1, 1'b0);
    checkIdle("ignoredInDone", 3);

    $display("[TB] reset mid-operation");
    dividend = 16'd50000;
    divisor  = 8'd250;
    start    = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checkAllZero("midReset");
    @(negedge clk);
    rst_n = 1'b1;
    checkIdle("afterReset", 12);
    applyStimulus(16'd250, 8'd10, 0, 1'b0);

    $display("[TB] randomized back-to-back divides");
    for (int v = 0; v < 1000; v++) begin
      sel = $urandom_range(0, 15);
      rdv = (sel == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (sel == 0)      rhi = 8'($urandom);
      else if (sel == 1) rhi = 8'($urandom_range(32'(rdv), 255));
      else               rhi = 8'($urandom_range(0, 32'(rdv) - 1));
      rlo = 8'($urandom);
      applyStimulus({rhi, rlo}, rdv, 0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 Parameter DW, default 8, SHALL set the operand width: dividend 2*DW bits; divisor, quotient and remainder DW bits each.
REQ-003 start  input  1  request pulse; sampled only in IDLE.
REQ-004 dividend  input  2*DW  unsigned dividend (16-bit product format of the SAP3 multiplier).
REQ-005 divisor  input  DW  unsigned divisor.
REQ-006 busy  output  1  high while iterating.
REQ-007 done  output  1  one-cycle pulse when results are valid.
REQ-008 quotient  output  DW  unsigned quotient.
REQ-009 remainder  output  DW  unsigned remainder.
REQ-010 div_by_zero  output  1  error flag: divisor == 0.
REQ-011 overflow  output  1  error flag: quotient does not fit in DW bits.

Function
REQ-012 The FSM SHALL have states IDLE, CALC and DONE, encoded as a shared enum.
REQ-013 In IDLE, with start=1, the block SHALL latch dividend and divisor.
REQ-014 Error checks at start: divisor==0 SHALL set div_by_zero; otherwise dividend[2DW-1:DW] >= divisor SHALL set overflow; on either error the FSM SHALL go directly to DONE with busy never asserted.
REQ-015 Otherwise the FSM SHALL load the partial remainder R (DW+1 bits) = {0, dividend high half}, load the quotient shift register Q = dividend low half, clear the step counter, and enter CALC.
REQ-016 Each CALC cycle SHALL perform one restoring step:
- shift {R,Q} left by 1;
- trial = shifted R - {0,divisor};
- if there is no borrow, R = trial and Q[0] = 1;
- otherwise R is kept and Q[0] = 0.
REQ-017 CALC SHALL last exactly DW cycles and then go to DONE.
REQ-018 busy SHALL be 1 exactly while in CALC.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-020 Latency from the start-sampling edge to done=1 SHALL be DW+1 cycles for a valid divide and 1 cycle for an error case.
REQ-021 quotient, remainder and the error flags SHALL update in the cycle done asserts and SHALL hold until the next accepted start.
- On error: quotient = all ones, remainder = 0.
REQ-022 start asserted in CALC or DONE SHALL be ignored and SHALL have no queuing effect.
REQ-023 Inputs SHALL be sampled only on the start edge; changes to dividend or divisor during CALC SHALL not affect the result.
REQ-024 Results SHALL satisfy dividend == quotient*divisor + remainder with remainder < divisor for all non-error inputs.
REQ-025 The error flags SHALL be cleared when a new start is accepted.

Reset
REQ-026 rst_n low SHALL immediately force:
- state to IDLE;
- busy, done, div_by_zero and overflow to 0;
- quotient, remainder, R, Q and the step counter to 0.
REQ-027 Reset asserted mid-CALC SHALL abort the operation; no done pulse SHALL follow after reset deasserts.
REQ-028 The first start after reset release SHALL be accepted normally.

Structure
REQ-029 Package sap3_div_pkg SHALL hold the FSM state enum, DW default and step-counter width ($clog2(DW+1)).
REQ-030 One combinational sub-module, div_step, SHALL compute the shift, trial subtract and quotient bit for a single step; seq_divider instantiates it once.
REQ-031 The design SHALL contain no multiplier or divide operator; subtraction only.

Verification
REQ-032 dividend=100, divisor=7, start pulse -> done 9 cycles later, quotient=14, remainder=2, flags 0.
REQ-033 dividend=0xFE01, divisor=0xFF -> quotient=0xFF, remainder=0x00; then dividend=0x00FF, divisor=0xFF -> quotient=1, remainder=0.
REQ-034 dividend=1000, divisor=0 -> done 1 cycle later, div_by_zero=1, quotient=0xFF, remainder=0, busy never high; dividend=0x0800, divisor=0x05 -> overflow=1.
REQ-035 Start 200/9, pulse start again plus new operands at CALC cycle 3 -> second start ignored, result quotient=22, remainder=2, single done pulse.
REQ-036 Start 50000/250 (overflow=0 check: 0xC3 < 0xFA), assert rst_n=0 at CALC cycle 4 -> outputs zero immediately, no done; after release, 250/10 -> quotient=25, remainder=0.
REQ-037 Randomized back-to-back starts (1000 vectors) checked against the arithmetic identity and the latency rules.
